// File: rtl/data_stack_if.sv
// Command/data bundle between the ALU control and the data stack.
// The stack uses the slave view; the driving controller uses master.
interface data_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic [1:0]             cmd;
  logic [WIDTH-1:0]       din;
  logic [WIDTH-1:0]       res;
  logic                   err_clr;
  logic [WIDTH-1:0]       tos;
  logic [WIDTH-1:0]       nos;
  logic [$clog2(DEPTH):0] depth;
  logic                   empty;
  logic                   full;
  logic                   ovf;
  logic                   unf;

  modport master (
    output cmd, din, res, err_clr,
    input  tos, nos, depth, empty, full, ovf, unf
  );

  modport slave (
    input  cmd, din, res, err_clr,
    output tos, nos, depth, empty, full, ovf, unf
  );
endinterface

// File: rtl/data_stack.sv
// Operand stack feeding a two-operand ALU: PUSH/POP/BINOP with sticky
// overflow/underflow flags and zero-latency TOS/NOS views.
module data_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  data_stack_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PUSH  = 2'b01;
  localparam logic [1:0] CMD_POP   = 2'b10;
  localparam logic [1:0] CMD_BINOP = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [DW-1:0]    depth_m1_s, depth_m2_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] tos_s, nos_s;

  assign depth_m1_s = depth_q - DW'(1);
  assign depth_m2_s = depth_q - DW'(2);

  // Next-state decode for depth, sticky flags and the single write port.
  always_comb begin
    depth_d   = depth_q;
    ovf_d     = ovf_q & ~bus.err_clr;
    unf_d     = unf_q & ~bus.err_clr;
    wr_en_s   = 1'b0;
    wr_idx_s  = depth_q[AW-1:0];
    wr_data_s = bus.din;
    case (bus.cmd)
      CMD_PUSH: begin
        if (depth_q < DEPTH_C) begin
          wr_en_s = 1'b1;
          depth_d = depth_q + DW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      CMD_POP: begin
        if (depth_q != DW'(0)) begin
          depth_d = depth_m1_s;
        end else begin
          unf_d = 1'b1;
        end
      end
      CMD_BINOP: begin
        // result overwrites NOS; TOS is discarded by the decrement
        if (depth_q >= DW'(2)) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = depth_m2_s[AW-1:0];
          wr_data_s = bus.res;
          depth_d   = depth_m1_s;
        end else begin
          unf_d = 1'b1;
        end
      end
      CMD_NOP: begin
        depth_d = depth_q;
      end
      default: begin
        depth_d = depth_q;
      end
    endcase
  end

  // Control state: depth and sticky flags, reset synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; contents are masked by depth so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

  // Zero-latency top/next views, masked to zero when not populated.
  always_comb begin
    tos_s = '0;
    nos_s = '0;
    if (depth_q != DW'(0)) begin
      tos_s = mem_q[depth_m1_s[AW-1:0]];
    end else begin
      tos_s = '0;
    end
    if (depth_q >= DW'(2)) begin
      nos_s = mem_q[depth_m2_s[AW-1:0]];
    end else begin
      nos_s = '0;
    end
  end

  assign bus.tos   = tos_s;
  assign bus.nos   = nos_s;
  assign bus.depth = depth_q;
  assign bus.empty = (depth_q == DW'(0));
  assign bus.full  = (depth_q == DEPTH_C);
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (matches ALU operand width).
REQ-002 Parameter: DEPTH, 16, number of stack entries; power of two, minimum 4.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd  in  2  stack command: 00 NOP, 01 PUSH, 10 POP, 11 BINOP.
REQ-007 din  in  WIDTH  value written by PUSH.
REQ-008 res  in  WIDTH  ALU result, sampled on BINOP.
REQ-009 err_clr  in  1  clears the sticky error flags.
REQ-010 tos  out  WIDTH  top of stack; drives ALU oper0.
REQ-011 nos  out  WIDTH  next of stack; drives ALU oper1.
REQ-012 depth  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-013 empty  out  1  high when depth==0.
REQ-014 full  out  1  high when depth==DEPTH.
REQ-015 ovf  out  1  sticky overflow flag.
REQ-016 unf  out  1  sticky underflow flag.

Function
REQ-017 tos, nos, empty and full shall be combinational from registered state, with zero latency.
- tos = entry[depth-1]
- nos = entry[depth-2]
REQ-018 tos shall read 0 when depth<1; nos shall read 0 when depth<2.
REQ-019 Each command shall take effect at the clk edge where it is sampled, and the new state shall be visible in the following cycle. The block is single-cycle with no handshake, and one command is accepted per cycle.
REQ-020 NOP shall leave all state unchanged.
REQ-021 PUSH with depth<DEPTH shall write din at index depth and increment depth.
REQ-022 PUSH with depth==DEPTH shall be dropped (stack and depth unchanged) and shall set ovf.
REQ-023 POP with depth>=1 shall decrement depth; the entry contents need not be cleared.
REQ-024 POP with depth==0 shall be dropped and shall set unf.
REQ-025 BINOP with depth>=2 shall:
- write res at index depth-2;
- decrement depth by 1.
Net effect: NOS and TOS are replaced by the ALU result.
REQ-026 BINOP with depth<2 shall be dropped and shall set unf.
REQ-027 res shall be sampled only on BINOP and shall not be width-extended. The block performs no arithmetic on data; only depth is incremented or decremented.
REQ-028 depth shall never wrap: no command moves it below 0 or above DEPTH.
REQ-029 err_clr shall clear ovf and unf at the next edge.
REQ-030 If err_clr coincides with a command that sets a flag, set shall win for that flag; the other flag is cleared.
REQ-031 ovf and unf shall remain set until err_clr or rst.
REQ-032 Entry array contents need not be reset; REQ-018 masking guarantees defined outputs after reset.

Reset
REQ-033 rst high at an edge shall force:
- depth=0, ovf=0, unf=0;
- tos=0, nos=0, empty=1, full=0 in the following cycle.
REQ-034 rst shall take priority over any simultaneous cmd or err_clr; the coincident command is discarded.
REQ-035 rst asserted mid-sequence (any depth, any flags) shall yield the same state as REQ-033. No partial command completes.

Verification
REQ-036 Reset then PUSH 0x05, PUSH 0x03 -> depth=2, tos=0x03, nos=0x05, empty=0.
REQ-037 From REQ-036, BINOP with res=0x02 (SUB result) -> depth=1, tos=0x02, nos=0x00.
REQ-038 PUSH 16 values 0x10..0x1F, then PUSH 0xAA -> full=1, depth=16, tos=0x1F, ovf=1.
REQ-039 From reset, POP -> unf=1, depth=0. Then PUSH 0x07, BINOP res=0xEE -> unf stays 1, depth=1, tos=0x07.
REQ-040 With unf=1 and depth=0, assert err_clr together with POP -> unf=1 (set wins). Then err_clr alone -> unf=0, ovf=0.
REQ-041 At depth=9 with ovf=1, assert rst together with PUSH 0x55 -> next cycle depth=0, tos=0, ovf=0, empty=1.
